// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, field positions, Status/Cause layouts and exception codes
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LO  = 8;
  localparam int STATUS_BEV    = 22;
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_IP_LO   = 8;
  localparam int CAUSE_BD      = 31;

  typedef struct packed {
    logic [8:0] rsvd_31_23;
    logic       bev;
    logic [5:0] rsvd_21_16;
    logic [7:0] im;
    logic [5:0] rsvd_7_2;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    logic        bd;
    logic [14:0] rsvd_30_16;
    logic [7:0]  ip;
    logic        rsvd_7;
    logic [4:0]  exc_code;
    logic [1:0]  rsvd_1_0;
  } cp0_cause_t;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// rtl/cp0_irq_ctrl_if.sv - pipeline/exception-unit side bundle of the CP0 block
interface cp0_irq_ctrl_if;
  logic        mem_stall;
  logic [5:0]  hw_int;
  logic        cp0_wen;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        exp_en;
  logic        exl_clean;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        exp_bd;
  logic [31:0] exp_bad_vaddr;
  logic        exp_bad_vaddr_wen;
  logic [31:0] epc_address;
  logic        allow_interrupt;
  logic [7:0]  interrupt_flag;

  modport master (
    output mem_stall, hw_int, cp0_wen, cp0_waddr, cp0_wdata, cp0_raddr,
           exp_en, exl_clean, exp_code, exp_epc, exp_bd, exp_bad_vaddr, exp_bad_vaddr_wen,
    input  cp0_rdata, epc_address, allow_interrupt, interrupt_flag
  );

  modport slave (
    input  mem_stall, hw_int, cp0_wen, cp0_waddr, cp0_wdata, cp0_raddr,
           exp_en, exl_clean, exp_code, exp_epc, exp_bd, exp_bad_vaddr, exp_bad_vaddr_wen,
    output cp0_rdata, epc_address, allow_interrupt, interrupt_flag
  );
endinterface

// File: rtl/cp0_int_sync.sv
// rtl/cp0_int_sync.sv - SYNC_STAGES-deep synchroniser for the six external interrupt levels
module cp0_int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] hw_int,
  output logic [5:0] hw_int_sync
);
  logic [5:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign hw_int_sync = stage_q[SYNC_STAGES-1];
endmodule

// File: rtl/cp0_irq_ctrl.sv
// rtl/cp0_irq_ctrl.sv - CP0 register file and interrupt controller beside the MEM/WB boundary
// Count/Compare timer is present only when CP0_TIMER_IRQ_EN is defined.
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] STATUS_RST  = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  cp0_irq_ctrl_if.slave bus
);
  cp0_status_t status_q;
  cp0_cause_t  cause;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        bd_q;
  logic [4:0]  exc_code_q;
  logic [1:0]  ip_sw_q;
  logic [5:0]  ip_hw_q;
  logic [5:0]  hw_int_sync;
  logic        commit;
  logic        mtc0;
  logic        exc;
  logic        eret;
  logic        timer_int;
  logic [31:0] count_q;
  logic [31:0] compare_q;

  assign commit = ~bus.mem_stall;
  assign mtc0   = bus.cp0_wen & commit;
  assign exc    = bus.exp_en & commit;
  assign eret   = bus.exl_clean & ~bus.exp_en & commit;

  cp0_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .hw_int      (bus.hw_int),
    .hw_int_sync (hw_int_sync)
  );

  // Exception/ERET assignments come last so they override a same-cycle MTC0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= cp0_status_t'(STATUS_RST);
    end else begin
      if (mtc0 && bus.cp0_waddr == CP0_STATUS) begin
        status_q.im  <= bus.cp0_wdata[STATUS_IM_LO +: 8];
        status_q.exl <= bus.cp0_wdata[STATUS_EXL];
        status_q.ie  <= bus.cp0_wdata[STATUS_IE];
      end
      if (exc) status_q.exl <= 1'b1;
      else if (eret) status_q.exl <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else if (commit) begin
      ip_hw_q <= hw_int_sync;
      if (mtc0 && bus.cp0_waddr == CP0_CAUSE) ip_sw_q <= bus.cp0_wdata[CAUSE_IP_LO +: 2];
      if (mtc0 && bus.cp0_waddr == CP0_EPC) epc_q <= bus.cp0_wdata;
      if (exc) begin
        bd_q       <= bus.exp_bd;
        exc_code_q <= bus.exp_code;
        epc_q      <= bus.exp_epc;
        if (bus.exp_bad_vaddr_wen) badvaddr_q <= bus.exp_bad_vaddr;
      end
    end
  end

`ifdef CP0_TIMER_IRQ_EN
  logic        tick_q;
  logic        timer_int_q;
  logic        wr_count;
  logic        wr_compare;
  logic        count_we;
  logic [31:0] count_nxt;

  assign wr_count   = mtc0 && bus.cp0_waddr == CP0_COUNT;
  assign wr_compare = mtc0 && bus.cp0_waddr == CP0_COMPARE;

  // Count advances on alternate cycles regardless of mem_stall.
  always_comb begin
    count_we  = 1'b0;
    count_nxt = count_q;
    if (wr_count) begin
      count_we  = 1'b1;
      count_nxt = bus.cp0_wdata;
    end else if (tick_q) begin
      count_we  = 1'b1;
      count_nxt = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q      <= 1'b0;
      count_q     <= '0;
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else begin
      tick_q <= wr_count ? 1'b0 : ~tick_q;
      if (count_we) count_q <= count_nxt;
      if (wr_compare) compare_q <= bus.cp0_wdata;
      if (wr_compare) timer_int_q <= 1'b0;
      else if (count_we && count_nxt == compare_q) timer_int_q <= 1'b1;
    end
  end

  assign timer_int = timer_int_q;
`else
  assign count_q   = '0;
  assign compare_q = '0;
  assign timer_int = 1'b0;
`endif

  always_comb begin
    cause          = '0;
    cause.bd       = bd_q;
    cause.ip       = {ip_hw_q[5] | timer_int, ip_hw_q[4:0], ip_sw_q};
    cause.exc_code = exc_code_q;
  end

  always_comb begin
    case (bus.cp0_raddr)
      CP0_BADVADDR: bus.cp0_rdata = badvaddr_q;
      CP0_COUNT:    bus.cp0_rdata = count_q;
      CP0_COMPARE:  bus.cp0_rdata = compare_q;
      CP0_STATUS:   bus.cp0_rdata = status_q;
      CP0_CAUSE:    bus.cp0_rdata = cause;
      CP0_EPC:      bus.cp0_rdata = epc_q;
      default:      bus.cp0_rdata = '0;
    endcase
  end

  assign bus.epc_address     = epc_q;
  assign bus.allow_interrupt = status_q.ie & ~status_q.exl;
  assign bus.interrupt_flag  = cause.ip & status_q.im;
endmodule
